// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state, status and AXI constants for axi_burst_writer
package gcd_pkg;

    // Burst writer control states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_RESP  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // ERR_CODE encodings
    localparam logic [1:0] ERR_OKAY    = 2'b00;
    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    // AXI4 protocol constants
    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B       = 3'd3;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

    // A burst may not cross this byte boundary
    localparam logic [12:0] BOUNDARY_4K = 13'd4096;

endpackage

// File: rtl/axi_burst_writer.sv
// rtl/axi_burst_writer.sv - single-command AXI4 INCR burst writer fed from a data stream
module axi_burst_writer
    import gcd_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'h0,
    parameter int         DATA_W = 64
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  CLKEN,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [31:0]           CMD_ADDR,
    input  logic [7:0]            CMD_LEN,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_W-1:0]     S_DATA,
    output logic                  DONE,
    output logic [1:0]            ERR_CODE,
    output logic                  BUSY,
    output logic [3:0]            M_AXI_AWID,
    output logic [31:0]           M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWLOCK,
    output logic [3:0]            M_AXI_AWCACHE,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [3:0]            M_AXI_BID,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_cnt;
    logic [1:0]  err_q;
    logic [12:0] span_end;
    logic        illegal;
    logic        last_beat;
    logic        cmd_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

    // End offset of the burst inside its 4 KB page; 13 bits so a crossing is visible
    assign span_end  = {1'b0, addr_q[11:0]} + (({5'd0, len_q} + 13'd1) << 3);
    assign illegal   = (addr_q[2:0] != 3'd0) || (span_end > BOUNDARY_4K);
    assign last_beat = (beat_cnt == len_q);

    // Handshakes only count on enabled edges so a frozen block never completes a transfer
    assign cmd_hs = CLKEN && (state == ST_IDLE) && CMD_VALID;
    assign aw_hs  = CLKEN && (state == ST_ADDR) && M_AXI_AWREADY;
    assign w_hs   = CLKEN && (state == ST_DATA) && S_VALID && M_AXI_WREADY;
    assign b_hs   = CLKEN && (state == ST_RESP) && M_AXI_BVALID;

    // Fixed AW attributes and registered command payload
    assign M_AXI_AWID    = AXI_ID;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = AXI_SIZE_8B;
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = AXI_CACHE_BUF_MOD;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_WDATA   = S_DATA;
    assign M_AXI_WSTRB   = '1;
    assign ERR_CODE      = err_q;

    // State register: reset forces IDLE at once, even mid-burst
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= ST_IDLE;
        end else if (CLKEN) begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_hs) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = illegal ? ST_FIN : ST_ADDR;
            ST_ADDR:  if (aw_hs) state_nxt = ST_DATA;
            ST_DATA:  if (w_hs && last_beat) state_nxt = ST_RESP;
            ST_RESP:  if (b_hs) state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Command capture, beat counting and status
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            addr_q   <= 32'd0;
            len_q    <= 8'd0;
            beat_cnt <= 8'd0;
            err_q    <= ERR_OKAY;
        end else if (CLKEN) begin
            if (cmd_hs) begin
                addr_q <= CMD_ADDR;
                len_q  <= CMD_LEN;
                err_q  <= ERR_OKAY;
            end
            if ((state == ST_CHECK) && illegal) begin
                err_q <= ERR_ILLEGAL;
            end
            if (aw_hs) begin
                beat_cnt <= 8'd0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (b_hs) begin
                err_q <= ((M_AXI_BRESP != AXI_RESP_OKAY) || (M_AXI_BID != AXI_ID)) ? ERR_SLAVE : ERR_OKAY;
            end
        end
    end

    // Outputs decoded from state; stream pass-throughs are gated by CLKEN
    always_comb begin
        CMD_READY     = (state == ST_IDLE);
        BUSY          = (state != ST_IDLE);
        DONE          = (state == ST_FIN);
        M_AXI_AWVALID = (state == ST_ADDR);
        M_AXI_WVALID  = 1'b0;
        S_READY       = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        if (state == ST_DATA) begin
            M_AXI_WVALID = S_VALID && CLKEN;
            S_READY      = M_AXI_WREADY && CLKEN;
            M_AXI_WLAST  = last_beat;
        end
        if (state == ST_RESP) begin
            M_AXI_BREADY = CLKEN;
        end
    end

endmodule

// File: tb/tb_axi_burst_writer.sv
// tb/tb_axi_burst_writer.sv - directed self-checking bench for axi_burst_writer
module tb_axi_burst_writer;

    localparam logic [3:0] TB_ID = 4'h3;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        CLKEN;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [31:0] CMD_ADDR;
    logic [7:0]  CMD_LEN;
    logic        S_VALID;
    logic        S_READY;
    logic [63:0] S_DATA;
    logic        DONE;
    logic [1:0]  ERR_CODE;
    logic        BUSY;
    logic [3:0]  M_AXI_AWID;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [3:0]  M_AXI_BID;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    int n_cmp = 0;
    int n_err = 0;

    axi_burst_writer #(.AXI_ID(TB_ID), .DATA_W(64)) dut (
        .CLK(CLK), .RESETn(RESETn), .CLKEN(CLKEN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .DONE(DONE), .ERR_CODE(ERR_CODE), .BUSY(BUSY),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        CMD_VALID     = 1'b0;
        CMD_ADDR      = 32'd0;
        CMD_LEN       = 8'd0;
        S_VALID       = 1'b0;
        S_DATA        = 64'd0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        M_AXI_BID     = 4'h0;
    endtask

    // One command end to end: the bench plays stream source and AXI slave.
    task automatic run_cmd(input string name, input logic [31:0] addr, input logic [7:0] len,
                           input bit legal, input bit stalls, input logic [1:0] bresp,
                           input logic [3:0] bid, input logic [63:0] data_base,
                           input int pause_beat, input int reset_beat, input logic [1:0] exp_err);
        int  beats;
        int  aw_cnt;
        int  done_cnt;
        int  done_cyc;
        int  cyc;
        bit  aw_done;
        bit  b_pend;
        bit  paused;
        bit  aw_hs;
        bit  w_hs;
        logic frz_wlast;
        beats = 0; aw_cnt = 0; done_cnt = 0; done_cyc = 0;
        aw_done = 0; b_pend = 0; paused = 0;

        @(negedge CLK);
        chk({name, "/cmd_ready"}, 64'(CMD_READY), 64'd1);
        CMD_VALID = 1'b1;
        CMD_ADDR  = addr;
        CMD_LEN   = len;
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;

        for (cyc = 1; cyc <= 400; cyc++) begin
            if (done_cnt > 0 && cyc > done_cyc + 2) break;

            if (reset_beat >= 0 && aw_done && beats == reset_beat) begin
                RESETn = 1'b0;
                #1;
                chk({name, "/rst_awvalid"}, 64'(M_AXI_AWVALID), 64'd0);
                chk({name, "/rst_wvalid"},  64'(M_AXI_WVALID),  64'd0);
                chk({name, "/rst_bready"},  64'(M_AXI_BREADY),  64'd0);
                chk({name, "/rst_sready"},  64'(S_READY),       64'd0);
                chk({name, "/rst_busy"},    64'(BUSY),          64'd0);
                chk({name, "/rst_done"},    64'(DONE),          64'd0);
                chk({name, "/rst_err"},     64'(ERR_CODE),      64'd0);
                idle_inputs();
                @(negedge CLK);
                RESETn = 1'b1;
                @(negedge CLK);
                chk({name, "/rst_cmd_ready"}, 64'(CMD_READY), 64'd1);
                return;
            end

            if (pause_beat >= 0 && !paused && aw_done && beats == pause_beat) begin
                paused        = 1;
                frz_wlast     = M_AXI_WLAST;
                CLKEN         = 1'b0;
                M_AXI_AWREADY = 1'b1;
                M_AXI_WREADY  = 1'b1;
                S_VALID       = 1'b1;
                S_DATA        = data_base + 64'(beats);
                for (int k = 0; k < 10; k++) begin
                    #1;
                    chk({name, "/frz_wvalid"}, 64'(M_AXI_WVALID), 64'd0);
                    chk({name, "/frz_sready"}, 64'(S_READY),      64'd0);
                    chk({name, "/frz_wlast"},  64'(M_AXI_WLAST),  64'(frz_wlast));
                    chk({name, "/frz_busy"},   64'(BUSY),         64'd1);
                    chk({name, "/frz_err"},    64'(ERR_CODE),     64'd0);
                    @(negedge CLK);
                end
                CLKEN = 1'b1;
            end

            M_AXI_AWREADY = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            M_AXI_WREADY  = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            S_VALID       = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            S_DATA        = data_base + 64'(beats);
            M_AXI_BVALID  = b_pend;
            M_AXI_BRESP   = bresp;
            M_AXI_BID     = bid;
            #1;

            if (cyc == 1) begin
                chk({name, "/err_cleared"}, 64'(ERR_CODE), 64'd0);
                chk({name, "/busy"},        64'(BUSY),     64'd1);
            end
            if (!legal) begin
                chk({name, "/no_awvalid"}, 64'(M_AXI_AWVALID), 64'd0);
            end
            if (!aw_done) begin
                chk({name, "/wvalid_pre_aw"}, 64'(M_AXI_WVALID), 64'd0);
            end

            aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
            w_hs  = M_AXI_WVALID && M_AXI_WREADY;
            if (aw_hs) begin
                aw_cnt++;
                chk({name, "/awaddr"},  64'(M_AXI_AWADDR),  64'(addr));
                chk({name, "/awlen"},   64'(M_AXI_AWLEN),   64'(len));
                chk({name, "/awid"},    64'(M_AXI_AWID),    64'(TB_ID));
                chk({name, "/awsize"},  64'(M_AXI_AWSIZE),  64'd3);
                chk({name, "/awburst"}, 64'(M_AXI_AWBURST), 64'd1);
                chk({name, "/awcache"}, 64'(M_AXI_AWCACHE), 64'h3);
                chk({name, "/awlock_prot"}, {60'd0, M_AXI_AWLOCK, M_AXI_AWPROT}, 64'd0);
            end
            if (w_hs || (S_VALID && S_READY)) begin
                chk({name, "/s_w_pair"}, 64'(S_VALID && S_READY), 64'(w_hs));
            end
            if (w_hs) begin
                chk({name, "/wdata"}, M_AXI_WDATA, data_base + 64'(beats));
                chk({name, "/wlast"}, 64'(M_AXI_WLAST), 64'(beats == int'(len)));
                chk({name, "/wstrb"}, 64'(M_AXI_WSTRB), 64'hFF);
                if (M_AXI_WLAST) b_pend = 1;
                beats++;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 0;
            if (DONE) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    chk({name, "/err_code"}, 64'(ERR_CODE), 64'(exp_err));
                end
            end
            if (done_cnt > 0 && cyc == done_cyc + 1) begin
                chk({name, "/idle_busy"},      64'(BUSY),      64'd0);
                chk({name, "/idle_cmd_ready"}, 64'(CMD_READY), 64'd1);
            end
            if (aw_hs) aw_done = 1;
            @(negedge CLK);
        end

        idle_inputs();
        chk({name, "/done_count"}, 64'(done_cnt), 64'd1);
        chk({name, "/aw_count"},   64'(aw_cnt),   legal ? 64'd1 : 64'd0);
        chk({name, "/beat_count"}, 64'(beats),    legal ? 64'(len) + 64'd1 : 64'd0);
        if (!legal) begin
            chk({name, "/done_latency"}, 64'(done_cyc), 64'd2);
        end
    endtask

    initial begin
        RESETn = 1'b0;
        CLKEN  = 1'b1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset/awvalid", 64'(M_AXI_AWVALID), 64'd0);
        chk("reset/wvalid",  64'(M_AXI_WVALID),  64'd0);
        chk("reset/bready",  64'(M_AXI_BREADY),  64'd0);
        chk("reset/sready",  64'(S_READY),       64'd0);
        chk("reset/done",    64'(DONE),          64'd0);
        chk("reset/busy",    64'(BUSY),          64'd0);
        chk("reset/err",     64'(ERR_CODE),      64'd0);
        RESETn = 1'b1;
        @(negedge CLK);
        chk("reset/cmd_ready", 64'(CMD_READY), 64'd1);

        //      name        addr          len    legal stall bresp  bid    data base               pause rst  err
        run_cmd("nominal",  32'h0000_1000, 8'd20, 1, 0, 2'b00, TB_ID, 64'hD000_0000_0000_0000, -1, -1, 2'b00);
        run_cmd("stall",    32'h0000_2000, 8'd20, 1, 1, 2'b00, TB_ID, 64'd0,                   -1, -1, 2'b00);
        run_cmd("cross4k",  32'h0000_0FF8, 8'd1,  0, 0, 2'b00, TB_ID, 64'd0,                   -1, -1, 2'b10);
        run_cmd("misalign", 32'h0000_1004, 8'd0,  0, 0, 2'b00, TB_ID, 64'd0,                   -1, -1, 2'b10);
        run_cmd("slverr",   32'h0000_3000, 8'd0,  1, 0, 2'b10, TB_ID, 64'h5A5A_0000_0000_0001, -1, -1, 2'b01);
        repeat (3) @(negedge CLK);
        chk("slverr/err_held", 64'(ERR_CODE), 64'd1);
        run_cmd("edge4k",   32'h0000_0F80, 8'd15, 1, 0, 2'b00, TB_ID, 64'h1111_0000_0000_0000, -1, -1, 2'b00);
        run_cmd("bid_bad",  32'h0000_4000, 8'd2,  1, 1, 2'b00, 4'h0,  64'h2222_0000_0000_0000, -1, -1, 2'b01);
        run_cmd("clken",    32'h0000_5000, 8'd20, 1, 0, 2'b00, TB_ID, 64'h3333_0000_0000_0000,  7, -1, 2'b00);
        run_cmd("rst_mid",  32'h0000_6000, 8'd20, 1, 0, 2'b00, TB_ID, 64'h4444_0000_0000_0000, -1,  5, 2'b00);
        run_cmd("post_rst", 32'h0000_7000, 8'd3,  1, 1, 2'b00, TB_ID, 64'h5555_0000_0000_0000, -1, -1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
